order_fetcher: RTL and testbench
================================

// Module: order_fetcher
// PURPOSE
//  Fetches convolution orders from external memory over a simple one-outstanding read port.
//  Each order is WORDS_PER_ORDER 32-bit words. Presents the active order as a packed word bus to the layer controller.
//  Sequences the calculate_start / calculate_finish handshake. Prefetches order n+1 while order n runs (double buffer).
// PARAMETERS
//  WORDS_PER_ORDER  18  words per order (word0=order ... word17=id)
//  ORDER_STRIDE     32  words between consecutive order slots in memory
// PORTS
//  system_clk        in   1    sole clock, all logic on posedge
//  rst_n             in   1    asynchronous active-low reset
//  task_start        in   1    1-cycle pulse: start a run of order_count orders
//  order_base_addr   in   32   byte address of order 0 word 0, sampled on task_start
//  order_count       in   8    number of orders in the run, sampled on task_start
//  rd_req            out  1    read request, held until rd_ack
//  rd_addr           out  32   byte address, stable while rd_req=1
//  rd_ack            in   1    request accepted (sampled with rd_req=1)
//  rd_valid          in   1    read data valid; exactly one per accepted request
//  rd_data           in   32   read data
//  calculate_start   out  1    1-cycle pulse: order_words now holds a new order
//  calculate_finish  in   1    level from the compute core; its rising edge ends the active order
//  order_words       out  32*WORDS_PER_ORDER  active order, word k at [32k+:32]
//  order_index       out  8    index of the active order within the run
//  busy              out  1    run in progress
//  all_done          out  1    1-cycle pulse after the last order finishes
// BEHAVIOUR
//  Reset: all outputs 0. order_words=0. Shadow buffer cleared. FSMs return to IDLE. finish edge register = 0.
//  Address of order i, word k = base + 4*(i*ORDER_STRIDE + k), modulo 2^32. Words are fetched in order k=0..N-1.
//  Fetch engine, at most one request outstanding:
//   F_IDLE -> F_REQ when an order remains to fetch and the shadow buffer is empty.
//   F_REQ: rd_req=1. On rd_ack -> F_DATA.
//   F_DATA: on rd_valid, store rd_data into shadow word k. rd_valid arriving in the same cycle as rd_ack is accepted.
//    - If k < N-1: k+1, go to F_REQ.
//    - If k = N-1: mark shadow full, go to F_IDLE.
//   rd_valid outside F_DATA/F_REQ-with-ack is ignored.
//  Control FSM:
//   C_IDLE: task_start latches base/count and sets busy=1 on the next edge.
//    - If count=0: pulse all_done one cycle after task_start, busy stays 0, no reads. Otherwise -> C_WAIT.
//   C_WAIT: when shadow full, copy shadow to order_words, clear shadow, set order_index, pulse calculate_start -> C_RUN.
//    These all happen on the same edge: order_words and calculate_start update together.
//   C_RUN: the fetch engine prefetches the next order.
//    On rising edge of calculate_finish (finish & ~finish_r1):
//    - If more orders remain: -> C_WAIT. calculate_start re-issues as soon as the shadow is full.
//      This takes 1 cycle when already prefetched.
//    - If this was the last order: all_done pulses, busy=0 -> C_IDLE. order_words keeps its last value.
//  calculate_finish edges outside C_RUN are ignored. If finish is still high on entry to C_RUN, it does not re-trigger.
//  task_start while busy is ignored.
//  Latency: first rd_req is 1 cycle after task_start.
//   calculate_start for order 0 is 1 cycle after the rd_valid of its last word.
//  Reset mid-operation aborts immediately and drops rd_req. A late rd_valid after reset is ignored.
// TESTING
//  1) count=1, base=0x1000, zero-wait memory returning addr/4:
//     -> 18 reqs at 0x1000..0x1044; word k = 0x400+k.
//     -> one calculate_start; after finish rising edge, all_done 1 cycle later; busy 0.
//  2) count=3, rd_ack and rd_valid delayed 3 cycles:
//     -> order 1 words fetched at 0x1080+ while order 0 runs.
//     -> each calculate_start exactly 1 cycle after the previous finish edge when prefetched.
//     -> order_index 0,1,2.
//  3) count=0 -> all_done pulse 1 cycle after task_start, no rd_req, busy never 1.
//  4) calculate_finish held high across two orders, plus a glitch while in C_WAIT
//     -> only true rising edges in C_RUN advance; no skipped order.
//  5) rst_n low mid-fetch of word 7 of order 1 -> all outputs 0 asynchronously.
//     A rd_valid 2 cycles later is ignored. A new task_start restarts from word 0 of order 0.
//  6) base=0xFFFFFFC0, count=2 -> addresses wrap through 0x00000000; words still land in correct k slots.

Source files
------------

// File: rtl/order_fetcher.sv
// order_fetcher: fetches convolution orders over a one-outstanding read port,
// double-buffers them (shadow -> active) and sequences the
// calculate_start / calculate_finish handshake with the compute core.
module order_fetcher #(
    parameter int unsigned WORDS_PER_ORDER = 18,
    parameter int unsigned ORDER_STRIDE    = 32
) (
    input  logic                           system_clk,
    input  logic                           rst_n,
    input  logic                           task_start,
    input  logic [31:0]                    order_base_addr,
    input  logic [7:0]                     order_count,
    output logic                           rd_req,
    output logic [31:0]                    rd_addr,
    input  logic                           rd_ack,
    input  logic                           rd_valid,
    input  logic [31:0]                    rd_data,
    output logic                           calculate_start,
    input  logic                           calculate_finish,
    output logic [32*WORDS_PER_ORDER-1:0]  order_words,
    output logic [7:0]                     order_index,
    output logic                           busy,
    output logic                           all_done
);

    localparam int unsigned   KW     = (WORDS_PER_ORDER > 1) ? $clog2(WORDS_PER_ORDER) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(WORDS_PER_ORDER - 1);

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_DATA} fetch_state_t;
    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_RUN} ctrl_state_t;

    fetch_state_t r_f_state, w_f_next;
    ctrl_state_t  r_c_state, w_c_next;

    // run parameters and fetch position
    logic [31:0]   r_base;
    logic [7:0]    r_count;
    logic [7:0]    r_fetch_idx;
    logic [KW-1:0] r_word_k;

    // shadow (prefetch) buffer
    logic [WORDS_PER_ORDER-1:0][31:0] r_shadow;
    logic                             r_shadow_full;

    // active-order side
    logic [7:0]                      r_next_idx;
    logic                            r_finish_r1;
    logic [32*WORDS_PER_ORDER-1:0]   r_order_words;
    logic [7:0]                      r_order_index;
    logic                            r_busy;
    logic                            r_all_done;
    logic                            r_calc_start;

    logic        w_run_start;
    logic        w_zero_start;
    logic        w_fetch_go;
    logic        w_accept;
    logic        w_last_word;
    logic        w_load;
    logic        w_finish_rise;
    logic        w_more_orders;
    logic        w_run_end;
    logic [31:0] w_word_off;

    assign w_run_start   = (r_c_state == C_IDLE) && task_start && (order_count != 8'd0);
    assign w_zero_start  = (r_c_state == C_IDLE) && task_start && (order_count == 8'd0);
    assign w_fetch_go    = w_run_start ||
                           (r_busy && (r_fetch_idx < r_count) && !r_shadow_full);
    assign w_accept      = rd_valid && ((r_f_state == F_DATA) ||
                                        ((r_f_state == F_REQ) && rd_ack));
    assign w_last_word   = (r_word_k == LAST_K);
    assign w_finish_rise = calculate_finish && !r_finish_r1;
    assign w_more_orders = (r_next_idx < r_count);

    // byte address of (order r_fetch_idx, word r_word_k), wrapping mod 2^32
    assign w_word_off = 32'(r_fetch_idx) * ORDER_STRIDE + 32'(r_word_k);
    assign rd_addr    = r_base + (w_word_off << 2);
    assign rd_req     = (r_f_state == F_REQ);

    // fetch and control state registers
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_state <= F_IDLE;
            r_c_state <= C_IDLE;
        end else begin
            r_f_state <= w_f_next;
            r_c_state <= w_c_next;
        end
    end

    // fetch engine next state: one request outstanding, data may ride with ack
    always_comb begin
        w_f_next = r_f_state;
        case (r_f_state)
            F_IDLE: begin
                if (w_fetch_go) w_f_next = F_REQ;
            end
            F_REQ: begin
                if (rd_ack) begin
                    if (w_accept) w_f_next = w_last_word ? F_IDLE : F_REQ;
                    else          w_f_next = F_DATA;
                end
            end
            F_DATA: begin
                if (w_accept) w_f_next = w_last_word ? F_IDLE : F_REQ;
            end
            default: w_f_next = F_IDLE;
        endcase
    end

    // control FSM next state plus load / run-end strobes
    always_comb begin
        w_c_next  = r_c_state;
        w_load    = 1'b0;
        w_run_end = 1'b0;
        case (r_c_state)
            C_IDLE: begin
                if (w_run_start) w_c_next = C_WAIT;
            end
            C_WAIT: begin
                if (r_shadow_full) begin
                    w_load   = 1'b1;
                    w_c_next = C_RUN;
                end
            end
            C_RUN: begin
                if (w_finish_rise) begin
                    if (w_more_orders) begin
                        w_c_next = C_WAIT;
                    end else begin
                        w_run_end = 1'b1;
                        w_c_next  = C_IDLE;
                    end
                end
            end
            default: w_c_next = C_IDLE;
        endcase
    end

    // run parameters, fetch position and shadow buffer fill / hand-over
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base        <= '0;
            r_count       <= '0;
            r_fetch_idx   <= '0;
            r_word_k      <= '0;
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_next_idx    <= '0;
            r_order_words <= '0;
            r_order_index <= '0;
        end else begin
            if (w_run_start) begin
                r_base      <= order_base_addr;
                r_count     <= order_count;
                r_fetch_idx <= '0;
                r_word_k    <= '0;
                r_next_idx  <= '0;
            end
            if (w_accept) begin
                r_shadow[r_word_k] <= rd_data;
                if (w_last_word) begin
                    r_word_k      <= '0;
                    r_fetch_idx   <= r_fetch_idx + 8'd1;
                    r_shadow_full <= 1'b1;
                end else begin
                    r_word_k <= r_word_k + KW'(1);
                end
            end
            if (w_load) begin
                r_order_words <= r_shadow;
                r_order_index <= r_next_idx;
                r_next_idx    <= r_next_idx + 8'd1;
                r_shadow      <= '0;
                r_shadow_full <= 1'b0;
            end
        end
    end

    // handshake outputs, busy flag and finish edge detector
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_calc_start <= 1'b0;
            r_all_done   <= 1'b0;
            r_busy       <= 1'b0;
            r_finish_r1  <= 1'b0;
        end else begin
            r_calc_start <= w_load;
            r_all_done   <= w_zero_start || w_run_end;
            r_finish_r1  <= calculate_finish;
            if (w_run_start)    r_busy <= 1'b1;
            else if (w_run_end) r_busy <= 1'b0;
        end
    end

    assign calculate_start = r_calc_start;
    assign order_words     = r_order_words;
    assign order_index     = r_order_index;
    assign busy            = r_busy;
    assign all_done        = r_all_done;

endmodule

// File: tb/tb_order_fetcher.sv
// Testbench for order_fetcher: memory model checks addresses against an
// expected-address queue; a monitor checks each calculate_start against an
// expected-order queue; table-driven runs plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_order_fetcher;

    localparam int N      = 18;
    localparam int STRIDE = 32;
    localparam int W      = 32*N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          task_start = 1'b0;
    logic [31:0]   order_base_addr = '0;
    logic [7:0]    order_count = '0;
    logic          rd_req;
    logic [31:0]   rd_addr;
    logic          rd_ack = 1'b0;
    logic          rd_valid = 1'b0;
    logic [31:0]   rd_data = '0;
    logic          calculate_start;
    logic          calculate_finish = 1'b0;
    logic [W-1:0]  order_words;
    logic [7:0]    order_index;
    logic          busy;
    logic          all_done;

    always #5 clk = ~clk;

    order_fetcher #(.WORDS_PER_ORDER(N), .ORDER_STRIDE(STRIDE)) dut (
        .system_clk       (clk),
        .rst_n            (rst_n),
        .task_start       (task_start),
        .order_base_addr  (order_base_addr),
        .order_count      (order_count),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_ack           (rd_ack),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .calculate_start  (calculate_start),
        .calculate_finish (calculate_finish),
        .order_words      (order_words),
        .order_index      (order_index),
        .busy             (busy),
        .all_done         (all_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 0;
    int n_ack = 0;
    int n_starts = 0;
    int n_done = 0;

    typedef struct packed {
        logic [7:0]   idx;
        logic [W-1:0] words;
    } ord_t;

    typedef struct {
        logic [31:0] base;
        int          cnt;
        int          lat;
        int          run_cyc;
        bit          gap_chk;
        int          exp_acks;
        int          exp_starts;
    } tv_t;

    logic [31:0] exp_addr_q[$];
    ord_t        exp_ord_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] waddr(input logic [31:0] base, input int i, input int k);
        return base + 32'((i*STRIDE + k)*4);
    endfunction

    function automatic logic [W-1:0] owords(input logic [31:0] base, input int i);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[32*k +: 32] = waddr(base, i, k) >> 2;
        return v;
    endfunction

    // push expected addresses and orders for orders [0, n_ord), first n_wlast words of the final one
    task automatic expect_orders(input logic [31:0] base, input int n_ord, input int n_extra_words);
        ord_t o;
        for (int i = 0; i < n_ord; i++) begin
            o.idx   = 8'(i);
            o.words = owords(base, i);
            exp_ord_q.push_back(o);
            for (int k = 0; k < N; k++) exp_addr_q.push_back(waddr(base, i, k));
        end
        for (int k = 0; k < n_extra_words; k++) exp_addr_q.push_back(waddr(base, n_ord, k));
    endtask

    // memory: returns addr/4 of the expected address, latency mem_lat for ack and for data
    initial begin : mem_model
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (rd_req === 1'b1) begin
                repeat (mem_lat) @(negedge clk);
                chk("rd_req_held", 32'(rd_req), 32'd1);
                if (exp_addr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rd_addr_unexpected: got %h expected no request", rd_addr);
                    a = rd_addr;
                end else begin
                    a = exp_addr_q.pop_front();
                    chk("rd_addr", rd_addr, a);
                end
                rd_ack = 1'b1;
                n_ack++;
                if (mem_lat == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = a >> 2;
                end
                @(negedge clk);
                rd_ack   = 1'b0;
                rd_valid = 1'b0;
                if (mem_lat > 0) begin
                    repeat (mem_lat - 1) @(negedge clk);
                    rd_valid = 1'b1;
                    rd_data  = a >> 2;
                    @(negedge clk);
                    rd_valid = 1'b0;
                end
            end
        end
    end

    // monitor: every calculate_start must match the next expected order
    always @(negedge clk) begin : monitor
        ord_t o;
        if (rst_n && calculate_start === 1'b1) begin
            n_starts++;
            if (exp_ord_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL calc_start_unexpected: got index %0d expected no pulse", order_index);
            end else begin
                o = exp_ord_q.pop_front();
                chk("order_index", 32'(order_index), 32'(o.idx));
                chk_w("order_words", order_words, o.words);
            end
        end
        if (rst_n && all_done === 1'b1) n_done++;
    end

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (calculate_start !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (calculate_start !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_start: got no calculate_start expected pulse within 2000 cycles");
        end
    endtask

    task automatic start_task(input logic [31:0] base, input int cnt);
        order_base_addr = base;
        order_count     = 8'(cnt);
        task_start      = 1'b1;
        @(negedge clk);
        task_start      = 1'b0;
        order_base_addr = 32'hDEAD_0000;
        order_count     = 8'hFF;
    endtask

    task automatic run_case(input tv_t tv);
        int   a0, s0, d0, cyc;
        logic saw;
        a0 = n_ack;
        s0 = n_starts;
        d0 = n_done;
        mem_lat = tv.lat;
        expect_orders(tv.base, tv.cnt, 0);
        start_task(tv.base, tv.cnt);
        chk("first_rd_req", 32'(rd_req), 32'(tv.cnt != 0));
        chk("busy_after_start", 32'(busy), 32'(tv.cnt != 0));
        chk("all_done_after_start", 32'(all_done), 32'(tv.cnt == 0));
        if (tv.cnt == 0) begin
            saw = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                saw = saw | rd_req | busy | all_done;
            end
            chk("zero_count_quiet", 32'(saw), 32'd0);
        end else begin
            for (int i = 0; i < tv.cnt; i++) begin
                wait_start(cyc);
                if (i > 0 && tv.gap_chk) chk("restart_gap", 32'(cyc), 32'd1);
                repeat (tv.run_cyc) @(negedge clk);
                calculate_finish = 1'b1;
                @(negedge clk);
                calculate_finish = 1'b0;
                if (i == tv.cnt - 1) begin
                    chk("all_done_pulse", 32'(all_done), 32'd1);
                    chk("busy_cleared", 32'(busy), 32'd0);
                    @(negedge clk);
                    chk("all_done_one_cycle", 32'(all_done), 32'd0);
                    chk_w("order_words_kept", order_words, owords(tv.base, tv.cnt - 1));
                end
            end
        end
        repeat (3) @(negedge clk);
        chk("acks", 32'(n_ack - a0), 32'(tv.exp_acks));
        chk("starts", 32'(n_starts - s0), 32'(tv.exp_starts));
        chk("done_pulses", 32'(n_done - d0), 32'd1);
        chk("queues_drained", 32'(exp_ord_q.size() + exp_addr_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test expected finish within 50000 cycles");
        $fatal(1, "timeout");
    end

    initial begin : main
        tv_t tv [4];
        tv_t t;
        int  cyc, a0, s0, d0;

        tv[0] = '{32'h0000_1000, 1, 0,  20, 1'b0, 18, 1};
        tv[1] = '{32'h0000_1000, 3, 3, 200, 1'b1, 54, 3};
        tv[2] = '{32'h0000_2000, 0, 0,   0, 1'b0,  0, 0};
        tv[3] = '{32'hFFFF_FFC0, 2, 1, 200, 1'b1, 36, 2};

        // reset state
        #1;
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_calc_start", 32'(calculate_start), 32'd0);
        chk_w("rst_order_words", order_words, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tv[i]) run_case(tv[i]);

        // glitch in C_WAIT, then finish held high across an order boundary
        a0 = n_ack;
        s0 = n_starts;
        d0 = n_done;
        mem_lat = 0;
        expect_orders(32'h0000_3000, 2, 0);
        start_task(32'h0000_3000, 2);
        repeat (3) @(negedge clk);
        calculate_finish = 1'b1;
        @(negedge clk);
        calculate_finish = 1'b0;
        chk("glitch_busy", 32'(busy), 32'd1);
        wait_start(cyc);
        repeat (10) @(negedge clk);
        chk("glitch_index", 32'(order_index), 32'd0);
        chk("glitch_no_done", 32'(n_done - d0), 32'd0);
        repeat (90) @(negedge clk);
        calculate_finish = 1'b1;
        @(negedge clk);
        wait_start(cyc);
        chk("held_gap", 32'(cyc), 32'd1);
        repeat (30) @(negedge clk);
        chk("held_no_done", 32'(n_done - d0), 32'd0);
        chk("held_busy", 32'(busy), 32'd1);
        chk("held_index", 32'(order_index), 32'd1);
        calculate_finish = 1'b0;
        repeat (3) @(negedge clk);
        calculate_finish = 1'b1;
        @(negedge clk);
        chk("held_all_done", 32'(all_done), 32'd1);
        calculate_finish = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_starts", 32'(n_starts - s0), 32'd2);
        chk("held_acks", 32'(n_ack - a0), 32'd36);

        // reset while order 1 word 7 is outstanding; late rd_valid must be dropped
        a0 = n_ack;
        mem_lat = 3;
        expect_orders(32'h0000_5000, 1, 8);
        start_task(32'h0000_5000, 2);
        wait_start(cyc);
        cyc = 0;
        while ((n_ack - a0) < 26 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        chk("abort_reached_word7", 32'(n_ack - a0), 32'd26);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_rd_req", 32'(rd_req), 32'd0);
        chk("abort_rd_addr", rd_addr, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_calc_start", 32'(calculate_start), 32'd0);
        chk("abort_all_done", 32'(all_done), 32'd0);
        chk("abort_index", 32'(order_index), 32'd0);
        chk_w("abort_order_words", order_words, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("late_valid_no_req", 32'(rd_req), 32'd0);
        chk("late_valid_idle", 32'(busy), 32'd0);
        chk("abort_queues", 32'(exp_ord_q.size() + exp_addr_q.size()), 32'd0);
        t = '{32'h0000_5000, 1, 0, 20, 1'b0, 18, 1};
        run_case(t);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
